axi_sram_responder: RTL and testbench



---
 rtl/axi_sram_responder.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_axi_sram_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_responder.sv
// AXI4 slave responder onto a 1-cycle SRAM; one transaction at a time, INCR/FIXED, SLVERR for range/WRAP/w.last errors.
// Latency: first R beat 2 cycles after AR, then 1 beat/cycle; writes hit the SRAM in the W handshake cycle.
// Backpressure: 2-entry fall-through R buffer throttles reads on r_ready; AXI_SRAM_RESPONDER_RR_ARB_EN enables AW/AR round-robin.
package ariane_axi_soc;
    typedef struct packed {
        logic [4:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic        user;
    } aw_chan_t;
    typedef struct packed {
        logic [4:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic        user;
    } ar_chan_t;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic        user;
    } w_chan_t;
    typedef struct packed {
        logic [4:0] id;
        logic [1:0] resp;
        logic       user;
    } b_chan_t;
    typedef struct packed {
        logic [4:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        user;
    } r_chan_t;
    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_slv_t;
    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_slv_t;
endpackage

module axi_sram_responder #(
    parameter int unsigned NumWords = 8192,
    parameter logic [63:0] BaseAddr = 64'h8000_0000,
    parameter int unsigned AddrBits = $clog2(NumWords)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [$bits(ariane_axi_soc::req_slv_t)-1:0]  axi_req_i,
    output logic [$bits(ariane_axi_soc::resp_slv_t)-1:0] axi_resp_o,
    output logic                                          mem_req_o,
    output logic                                          mem_we_o,
    output logic [AddrBits-1:0]                           mem_addr_o,
    output logic [63:0]                                   mem_wdata_o,
    output logic [7:0]                                    mem_be_o,
    input  logic [63:0]                                   mem_rdata_i
);
    localparam logic [63:0] MemBytes   = 64'(NumWords) << 3;
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_e;

    ariane_axi_soc::req_slv_t  req;
    ariane_axi_soc::resp_slv_t resp;
    assign req        = axi_req_i;
    assign axi_resp_o = resp;

    state_e      state_q, state_d;
    logic        rdy_q, rdy_d, prio_q, prio_d, err_q, err_d, done_q, done_d;
    logic [4:0]  id_q, id_d;
    logic [63:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d, cnt_q, cnt_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic        infl_q, infl_d, infl_err_q, infl_err_d, infl_last_q, infl_last_d;
    logic [63:0] buf_dat_q [2];
    logic [63:0] buf_dat_d [2];
    logic [1:0]  buf_err_q, buf_err_d, buf_last_q, buf_last_d;
    logic        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]  occ_q, occ_d;

    logic [63:0] off, addr_nxt, r_dat;
    logic        beat_err, last_beat, aw_rdy, ar_rdy, aw_hs, ar_hs, w_hs;
    logic        r_vld, r_err, r_last, r_pop, rd_issue, push, pop, unused_fields;
    logic [2:0]  pend;

    assign off       = addr_q - BaseAddr;
    assign beat_err  = (off >= MemBytes) || (burst_q == 2'b10);
    assign last_beat = (cnt_q == len_q);
    assign addr_nxt  = (burst_q == 2'b01) ? addr_q + (64'd1 << size_q) : addr_q;

    // Contended AW/AR: only the favoured channel sees ready, so exactly one handshake can happen.
    assign aw_rdy = rdy_q && !(req.ar_valid && prio_q);
    assign ar_rdy = rdy_q && !(req.aw_valid && !prio_q);
    assign aw_hs  = req.aw_valid && aw_rdy;
    assign ar_hs  = req.ar_valid && ar_rdy;
    assign w_hs   = (state_q == WRITE) && req.w_valid;

    // Buffer head first, otherwise the beat arriving from the SRAM this cycle falls through.
    assign r_vld  = (state_q == READ) && ((occ_q != 2'd0) || infl_q);
    assign r_dat  = (occ_q != 2'd0) ? buf_dat_q[rptr_q] : (infl_err_q ? 64'd0 : mem_rdata_i);
    assign r_err  = (occ_q != 2'd0) ? buf_err_q[rptr_q] : infl_err_q;
    assign r_last = (occ_q != 2'd0) ? buf_last_q[rptr_q] : infl_last_q;
    assign r_pop  = r_vld && req.r_ready;

    assign pend     = 3'(occ_q) + 3'(infl_q) - 3'(r_pop);
    assign rd_issue = (state_q == READ) && !done_q && (pend < 3'd2);
    assign push     = infl_q && !((occ_q == 2'd0) && r_pop);
    assign pop      = r_pop && (occ_q != 2'd0);

    assign mem_req_o   = (w_hs || rd_issue) && !beat_err;
    assign mem_we_o    = w_hs && !beat_err;
    assign mem_addr_o  = mem_req_o ? off[AddrBits+2:3] : '0;
    assign mem_wdata_o = mem_we_o ? req.w.data : 64'd0;
    assign mem_be_o    = mem_we_o ? req.w.strb : 8'd0;

    assign unused_fields = ^{req.aw.lock, req.aw.cache, req.aw.prot, req.aw.qos, req.aw.region,
                             req.aw.atop, req.aw.user, req.ar.lock, req.ar.cache, req.ar.prot,
                             req.ar.qos, req.ar.region, req.ar.user, req.w.user};

    always_comb begin
        resp          = '0;
        resp.aw_ready = aw_rdy;
        resp.ar_ready = ar_rdy;
        resp.w_ready  = (state_q == WRITE);
        resp.b_valid  = (state_q == WRESP);
        if (state_q == WRESP) begin
            resp.b.id   = id_q;
            resp.b.resp = err_q ? RespSlvErr : RespOkay;
        end
        resp.r_valid = r_vld;
        if (r_vld) begin
            resp.r.id   = id_q;
            resp.r.data = r_dat;
            resp.r.resp = r_err ? RespSlvErr : RespOkay;
            resp.r.last = r_last;
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        err_d   = err_q;
        done_d  = done_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    {id_d, addr_d, len_d, size_d, burst_d} =
                        {req.aw.id, req.aw.addr, req.aw.len, req.aw.size, req.aw.burst};
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    state_d = WRITE;
                end else if (ar_hs) begin
                    {id_d, addr_d, len_d, size_d, burst_d} =
                        {req.ar.id, req.ar.addr, req.ar.len, req.ar.size, req.ar.burst};
                    cnt_d   = 8'd0;
                    done_d  = 1'b0;
                    state_d = READ;
                end
`ifdef AXI_SRAM_RESPONDER_RR_ARB_EN
                if (aw_hs || ar_hs) prio_d = ~prio_q;
`endif
            end
            WRITE: begin
                if (w_hs) begin
                    // A misplaced w.last only taints the response; the burst still ends on len.
                    if (beat_err || (req.w.last != last_beat)) err_d = 1'b1;
                    addr_d = addr_nxt;
                    cnt_d  = cnt_q + 8'd1;
                    if (last_beat) state_d = WRESP;
                end
            end
            WRESP: if (req.b_ready) state_d = IDLE;
            READ: begin
                if (rd_issue) begin
                    addr_d = addr_nxt;
                    cnt_d  = cnt_q + 8'd1;
                    if (last_beat) done_d = 1'b1;
                end
                if (r_pop && r_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rdy_d       = (state_d == IDLE);
        infl_d      = rd_issue;
        infl_err_d  = beat_err;
        infl_last_d = last_beat;

        buf_dat_d  = buf_dat_q;
        buf_err_d  = buf_err_q;
        buf_last_d = buf_last_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (push) begin
            buf_dat_d[wptr_q]  = infl_err_q ? 64'd0 : mem_rdata_i;
            buf_err_d[wptr_q]  = infl_err_q;
            buf_last_d[wptr_q] = infl_last_q;
            wptr_d             = ~wptr_q;
        end
        if (pop) rptr_d = ~rptr_q;
        occ_d = occ_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b0;
            prio_q      <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            cnt_q       <= '0;
            infl_q      <= 1'b0;
            infl_err_q  <= 1'b0;
            infl_last_q <= 1'b0;
            buf_dat_q   <= '{default: '0};
            buf_err_q   <= '0;
            buf_last_q  <= '0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            prio_q      <= prio_d;
            err_q       <= err_d;
            done_q      <= done_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            cnt_q       <= cnt_d;
            infl_q      <= infl_d;
            infl_err_q  <= infl_err_d;
            infl_last_q <= infl_last_d;
            buf_dat_q   <= buf_dat_d;
            buf_err_q   <= buf_err_d;
            buf_last_q  <= buf_last_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            occ_q       <= occ_d;
        end
    end
endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: scoreboard queues for SRAM writes, B and R, with a shadow memory model.
module tb_axi_sram_responder;
    localparam int          NW   = 8192;
    localparam int          AB   = 13;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] MEMB = 64'(NW) * 64'd8;

    typedef struct packed { logic [AB-1:0] addr; logic [63:0] data; logic [7:0] be; } wexp_t;
    typedef struct packed { logic [4:0] id; logic [1:0] resp; } bexp_t;
    typedef struct packed { logic [4:0] id; logic [63:0] data; logic [1:0] resp; logic last; } rexp_t;

    logic clk_i = 1'b0;
    logic rst_ni;
    ariane_axi_soc::req_slv_t  req;
    ariane_axi_soc::resp_slv_t resp;
    logic [$bits(ariane_axi_soc::req_slv_t)-1:0]  axi_req;
    logic [$bits(ariane_axi_soc::resp_slv_t)-1:0] axi_resp;
    logic          mem_req_o, mem_we_o;
    logic [AB-1:0] mem_addr_o;
    logic [63:0]   mem_wdata_o, mem_rdata;
    logic [7:0]    mem_be_o;
    logic [63:0]   sram   [NW];
    logic [63:0]   shadow [NW];

    wexp_t exp_w[$];
    bexp_t exp_b[$];
    rexp_t exp_r[$];
    int n_cmp = 0, n_fail = 0, mem_req_cnt = 0;

    assign axi_req = req;
    assign resp    = axi_resp;

    always #5 clk_i = ~clk_i;

    axi_sram_responder dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .axi_req_i(axi_req), .axi_resp_o(axi_resp),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata)
    );

    always @(posedge clk_i) begin
        if (mem_req_o && !mem_we_o) mem_rdata <= sram[mem_addr_o];
        if (mem_req_o && mem_we_o)
            for (int i = 0; i < 8; i++)
                if (mem_be_o[i]) sram[mem_addr_o][8*i +: 8] <= mem_wdata_o[8*i +: 8];
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            if (mem_req_o) mem_req_cnt++;
            if (mem_req_o && mem_we_o) begin
                check("mem_wr_expected", 128'(exp_w.size() != 0), 128'd1);
                if (exp_w.size() != 0) check("mem_wr", {mem_addr_o, mem_wdata_o, mem_be_o}, exp_w.pop_front());
            end
            if (resp.b_valid && req.b_ready) begin
                check("b_expected", 128'(exp_b.size() != 0), 128'd1);
                if (exp_b.size() != 0) check("b_beat", {resp.b.id, resp.b.resp}, exp_b.pop_front());
            end
            if (resp.r_valid && req.r_ready) begin
                check("r_expected", 128'(exp_r.size() != 0), 128'd1);
                if (exp_r.size() != 0)
                    check("r_beat", {resp.r.id, resp.r.data, resp.r.resp, resp.r.last}, exp_r.pop_front());
            end
        end
    end

    task automatic model_write(input logic [4:0] id, input logic [63:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb,
                               input int bad, input logic [63:0] base_d);
        logic [63:0] a, o, d;
        logic err;
        a = addr; err = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            o = a - BASE;
            d = base_d * 64'(b + 1);
            if (burst == 2'b10 || o >= MEMB) err = 1'b1;
            else begin
                exp_w.push_back('{addr: o[AB+2:3], data: d, be: strb});
                for (int i = 0; i < 8; i++) if (strb[i]) shadow[o[AB+2:3]][8*i +: 8] = d[8*i +: 8];
            end
            if (b == bad) err = 1'b1;
            if (burst == 2'b01) a = a + (64'd1 << size);
        end
        exp_b.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
    endtask

    task automatic model_read(input logic [4:0] id, input logic [63:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, output int nvalid);
        logic [63:0] a, o;
        logic err;
        a = addr; nvalid = 0;
        for (int b = 0; b <= int'(len); b++) begin
            o = a - BASE;
            err = (burst == 2'b10) || (o >= MEMB);
            exp_r.push_back('{id: id, data: err ? 64'd0 : shadow[o[AB+2:3]],
                              resp: err ? 2'b10 : 2'b00, last: (b == int'(len))});
            if (!err) nvalid++;
            if (burst == 2'b01) a = a + (64'd1 << size);
        end
    endtask

    // which: 0 aw_ready, 1 w_ready, 2 b_valid, 3 ar_ready
    task automatic wait_hs(input int which, input string tag);
        int n;
        logic ok;
        n = 0; ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk_i);
            n++;
            case (which)
                0: ok = resp.aw_ready;
                1: ok = resp.w_ready;
                2: ok = resp.b_valid;
                default: ok = resp.ar_ready;
            endcase
        end
        check(tag, 128'(ok), 128'd1);
    endtask

    task automatic do_write(input logic [4:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb,
                            input int bad, input logic [63:0] base_d);
        model_write(id, addr, len, size, burst, strb, bad, base_d);
        req.aw.id = id; req.aw.addr = addr; req.aw.len = len; req.aw.size = size; req.aw.burst = burst;
        req.aw_valid = 1'b1;
        wait_hs(0, "aw_timeout");
        @(posedge clk_i); #1;
        req.aw_valid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            req.w.data = base_d * 64'(b + 1);
            req.w.strb = strb;
            req.w.last = (b == int'(len)) ^ (b == bad);
            req.w_valid = 1'b1;
            wait_hs(1, "w_timeout");
            @(posedge clk_i); #1;
        end
        req.w_valid = 1'b0;
        req.b_ready = 1'b1;
        wait_hs(2, "b_timeout");
        @(posedge clk_i); #1;
        req.b_ready = 1'b0;
    endtask

    // mode 0: r_ready high; 1: stall 3 cycles after first beat; 2: reset after first beat
    task automatic do_read(input logic [4:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
        int nvalid, lat, n, c0;
        model_read(id, addr, len, size, burst, nvalid);
        c0 = mem_req_cnt;
        req.ar.id = id; req.ar.addr = addr; req.ar.len = len; req.ar.size = size; req.ar.burst = burst;
        req.ar_valid = 1'b1;
        req.r_ready = 1'b1;
        wait_hs(3, "ar_timeout");
        @(posedge clk_i); #1;
        req.ar_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
        end while (!resp.r_valid && lat < 20);
        check("r_first_latency", 128'(lat), 128'd2);
        if (mode == 2) begin
            @(posedge clk_i); #1;
            rst_ni = 1'b0;
            @(negedge clk_i);
            check("rst_mid_r_valid", 128'(resp.r_valid), 128'd0);
            check("rst_mid_ar_ready", 128'(resp.ar_ready), 128'd0);
            exp_r.delete();
            @(posedge clk_i); #1;
            rst_ni = 1'b1;
            req.r_ready = 1'b0;
            return;
        end
        if (mode == 1) begin
            @(posedge clk_i); #1;
            req.r_ready = 1'b0;
            repeat (3) @(negedge clk_i);
            check("stall_mem_req", 128'(mem_req_o), 128'd0);
            check("stall_hold", {resp.r_valid, resp.r.data}, {1'b1, exp_r[0].data});
            @(posedge clk_i); #1;
            req.r_ready = 1'b1;
        end
        n = 0;
        while (!(resp.r_valid && req.r_ready && resp.r.last) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("r_last_timeout", 128'(n < 100), 128'd1);
        if (mode == 0) check("r_back_to_back", 128'(n), 128'(len));
        check("r_mem_strobes", 128'(mem_req_cnt - c0), 128'(nvalid));
        @(posedge clk_i); #1;
        req.r_ready = 1'b0;
    endtask

    task automatic do_pair(input logic [63:0] waddr, input logic [63:0] wdata, input logic [63:0] raddr,
                           input logic exp_write_first, input string tag);
        int nv, n;
        logic granted, b_done, r_done, hs_aw, hs_ar, hs_w;
        if (exp_write_first) begin
            model_write(5'd1, waddr, 8'd0, 3'd3, 2'b01, 8'hFF, -1, wdata);
            model_read(5'd2, raddr, 8'd0, 3'd3, 2'b01, nv);
        end else begin
            model_read(5'd2, raddr, 8'd0, 3'd3, 2'b01, nv);
            model_write(5'd1, waddr, 8'd0, 3'd3, 2'b01, 8'hFF, -1, wdata);
        end
        req.aw.id = 5'd1; req.aw.addr = waddr; req.aw.len = 8'd0; req.aw.size = 3'd3; req.aw.burst = 2'b01;
        req.ar.id = 5'd2; req.ar.addr = raddr; req.ar.len = 8'd0; req.ar.size = 3'd3; req.ar.burst = 2'b01;
        req.w.data = wdata; req.w.strb = 8'hFF; req.w.last = 1'b1;
        req.aw_valid = 1'b1; req.ar_valid = 1'b1; req.w_valid = 1'b1;
        req.b_ready = 1'b1; req.r_ready = 1'b1;
        granted = 1'b0; b_done = 1'b0; r_done = 1'b0; n = 0;
        while (!(b_done && r_done) && n < 200) begin
            @(negedge clk_i);
            n++;
            hs_aw = req.aw_valid && resp.aw_ready;
            hs_ar = req.ar_valid && resp.ar_ready;
            hs_w  = req.w_valid && resp.w_ready;
            if (!granted && (hs_aw || hs_ar)) begin
                granted = 1'b1;
                check(tag, {hs_aw, hs_ar}, exp_write_first ? 2'b10 : 2'b01);
            end
            if (resp.b_valid) b_done = 1'b1;
            if (resp.r_valid && resp.r.last) r_done = 1'b1;
            @(posedge clk_i); #1;
            if (hs_aw) req.aw_valid = 1'b0;
            if (hs_ar) req.ar_valid = 1'b0;
            if (hs_w)  req.w_valid  = 1'b0;
        end
        check("pair_timeout", 128'(b_done && r_done), 128'd1);
        req.aw_valid = 1'b0; req.ar_valid = 1'b0; req.w_valid = 1'b0;
        req.b_ready = 1'b0; req.r_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        req = '0;
        @(negedge clk_i);
        check("rst_resp", axi_resp, '0);
        check("rst_mem", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, '0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        logic pair2_write_first;
        req = '0;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        do_reset();

        do_write(5'd5, BASE + 64'h10, 8'd3, 3'd3, 2'b01, 8'hFF, -1, 64'h11);
        do_read(5'd3, BASE + 64'h10, 8'd3, 3'd3, 2'b01, 0);
        do_read(5'd4, BASE + 64'h10, 8'd3, 3'd3, 2'b01, 1);
        do_read(5'd6, BASE + 64'h10, 8'd1, 3'd2, 2'b01, 0);
        do_write(5'd6, BASE + 64'h40, 8'd1, 3'd3, 2'b00, 8'h0F, -1, 64'h0102_0304_0506_0708);
        do_read(5'd6, BASE + 64'h40, 8'd1, 3'd3, 2'b00, 0);
        do_write(5'd9, BASE + MEMB - 64'd8, 8'd0, 3'd3, 2'b01, 8'hFF, -1, 64'hDEAD_BEEF);
        do_read(5'd9, BASE + MEMB - 64'd8, 8'd0, 3'd3, 2'b01, 0);
        do_read(5'd7, BASE + MEMB, 8'd1, 3'd3, 2'b01, 0);
        do_read(5'd8, BASE, 8'd1, 3'd3, 2'b10, 0);
        do_write(5'd10, BASE + 64'h60, 8'd0, 3'd3, 2'b10, 8'hFF, -1, 64'h55);
        do_write(5'd10, BASE + MEMB + 64'h8, 8'd0, 3'd3, 2'b01, 8'hFF, -1, 64'h77);
        do_write(5'd11, BASE + 64'h70, 8'd1, 3'd3, 2'b01, 8'hFF, 0, 64'h66);

        do_reset();
        do_pair(BASE + 64'h100, 64'hAA, BASE + 64'h100, 1'b1, "arb_after_reset");
        do_write(5'd12, BASE + 64'h110, 8'd0, 3'd3, 2'b01, 8'hFF, -1, 64'hCC);
`ifdef AXI_SRAM_RESPONDER_RR_ARB_EN
        pair2_write_first = 1'b0;
`else
        pair2_write_first = 1'b1;
`endif
        do_pair(BASE + 64'h108, 64'hBB, BASE + 64'h100, pair2_write_first, "arb_second_pair");

        do_read(5'd12, BASE + 64'h10, 8'd3, 3'd3, 2'b01, 2);
        do_write(5'd13, BASE + 64'h200, 8'd1, 3'd3, 2'b01, 8'hFF, -1, 64'h1234);
        do_read(5'd14, BASE + 64'h200, 8'd1, 3'd3, 2'b01, 0);

        repeat (2) @(negedge clk_i);
        check("leftover_w", 128'(exp_w.size()), 128'd0);
        check("leftover_b", 128'(exp_b.size()), 128'd0);
        check("leftover_r", 128'(exp_r.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
